// File: rtl/cpu_wb_dbus_master.sv
// Wishbone classic data-bus master for the MiniMIPS32 memory stage.
// One registered access at a time; stalls the pipe until ack, err or timeout.
module cpu_wb_dbus_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        flush_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        cpu_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             discard_q;
  logic             req;
  logic             ack_hit;
  logic             abort;
  logic             unused_addr;

  // Byte offset is dropped: the bus is word addressed.
  assign unused_addr = ^cpu_addr_i[1:0];

  // State register; reset drops cyc/stb at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state, bus strobes and stall.
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    ack_hit     = 1'b0;
    abort       = 1'b0;
    cpu_stall_o = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req         = cpu_ce_i & ~flush_i & wb_rst_i;
        cpu_stall_o = req;
        if (req) state_d = BUS;
      end
      BUS: begin
        wb_cyc_o    = 1'b1;
        wb_stb_o    = 1'b1;
        cpu_stall_o = 1'b1;
        if (wb_ack_i) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (wb_err_i ||
                     cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout count, read data and error pulse.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb_adr_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      cpu_rdata_o <= '0;
      cpu_err_o   <= 1'b0;
    end else begin
      if (req) begin
        wb_adr_o  <= {cpu_addr_i[31:2], 2'b00};
        wb_we_o   <= cpu_we_i;
        wb_sel_o  <= cpu_sel_i;
        wb_dat_o  <= cpu_wdata_i;
        cnt_q     <= '0;
        discard_q <= 1'b0;
      end
      if (state_q == BUS) begin
        if (flush_i) discard_q <= 1'b1;
        if (!ack_hit && !abort)
          cnt_q <= cnt_q + 1'b1;
      end
      if (ack_hit && !wb_we_o)
        cpu_rdata_o <= wb_dat_i;
      cpu_err_o <= abort & ~discard_q;
    end
  end

endmodule

// File: tb/tb_cpu_wb_dbus_master.sv
// Directed bench for cpu_wb_dbus_master.
// Slave is modelled by forced/combinational ack and err.
module tb_cpu_wb_dbus_master;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        cyc;
  logic        stb;
  logic        wwe;
  logic [31:0] adr;
  logic [3:0]  wsel;
  logic [31:0] dato;
  logic [31:0] dati;
  logic        ack;
  logic        werr;
  logic        ack_comb;
  logic        ack_force;
  logic        err_force;

  int n_chk;
  int n_fail;

  assign ack  = ack_force | (ack_comb & cyc & stb);
  assign werr = err_force;

  cpu_wb_dbus_master #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .cpu_ce_i(ce),
    .cpu_we_i(we),
    .cpu_addr_i(addr),
    .cpu_sel_i(sel),
    .cpu_wdata_i(wdata),
    .flush_i(flush),
    .cpu_rdata_o(rdata),
    .cpu_stall_o(stall),
    .cpu_err_o(err),
    .wb_cyc_o(cyc),
    .wb_stb_o(stb),
    .wb_we_o(wwe),
    .wb_adr_o(adr),
    .wb_sel_o(wsel),
    .wb_dat_o(dato),
    .wb_dat_i(dati),
    .wb_ack_i(ack),
    .wb_err_i(werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ce = 0; we = 0; flush = 0;
    ack_comb = 0; ack_force = 0;
    err_force = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    addr = 0; sel = 0; wdata = 0; dati = 0;
    rst_n = 0;
    #12;
    n_chk++;
    if ({cyc, stb, stall, err, wwe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000",
               {cyc, stb, stall, err, wwe});
    end
    n_chk++;
    if ({adr, dato, rdata, wsel} !== 100'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h expected 0",
               adr, dato, rdata, wsel);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_comb();
    ce = 1; we = 0; addr = 32'h0000_1006;
    sel = 4'hF; ack_comb = 1;
    dati = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if ({stall, cyc} !== 2'b10) begin
      n_fail++;
      $display("FAIL ld_req: got %b expected 10",
               {stall, cyc});
    end
    tick();
    n_chk++;
    if ({stall, cyc, stb, wwe} !== 4'b1110) begin
      n_fail++;
      $display("FAIL ld_bus: got %b expected 1110",
               {stall, cyc, stb, wwe});
    end
    n_chk++;
    if (adr !== 32'h0000_1004) begin
      n_fail++;
      $display("FAIL ld_adr: got %h expected 00001004", adr);
    end
    tick();
    n_chk++;
    if ({stall, cyc, stb, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL ld_done: got %b expected 0000",
               {stall, cyc, stb, err});
    end
    n_chk++;
    if (rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ld_data: got %h expected deadbeef", rdata);
    end
    idle_inputs();
    tick();
    n_chk++;
    if ({stall, cyc} !== 2'b00) begin
      n_fail++;
      $display("FAIL ld_idle: got %b expected 00",
               {stall, cyc});
    end
  endtask

  task automatic test_store();
    ce = 1; we = 1; addr = 32'h0000_2002;
    sel = 4'b0011; wdata = 32'h1234_5678;
    dati = 32'h5555_5555;
    tick();
    wdata = 32'hFFFF_0000;
    #1;
    n_chk++;
    if ({cyc, wwe, wsel} !== 6'b11_0011) begin
      n_fail++;
      $display("FAIL st_bus: got %b expected 110011",
               {cyc, wwe, wsel});
    end
    chk("st_adr", adr, 32'h0000_2000);
    tick();
    chk("st_dat_hold", dato, 32'h1234_5678);
    ack_force = 1;
    tick();
    ack_force = 0;
    ce = 0;
    chk("st_rdata", rdata, 32'hDEAD_BEEF);
    n_chk++;
    if ({err, stall, cyc} !== 3'b000) begin
      n_fail++;
      $display("FAIL st_done: got %b expected 000",
               {err, stall, cyc});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_delayed();
    int nstall;
    nstall = 0;
    ce = 1; we = 0; addr = 32'h0000_3008;
    sel = 4'hF; dati = 32'h1111_1111;
    #1;
    if (stall) nstall++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stall) nstall++;
      n_chk++;
      if ({cyc, stb} !== 2'b11 ||
          adr !== 32'h0000_3008) begin
        n_fail++;
        $display("FAIL dl_bus%0d: got %b %h expected 11 00003008",
                 i, {cyc, stb}, adr);
      end
      if (i < 3)
        chk("dl_nocapture", rdata, 32'hDEAD_BEEF);
      if (i == 3) begin
        ack_force = 1;
        dati = 32'hA5A5_5A5A;
      end
    end
    tick();
    ack_force = 0;
    dati = 32'h2222_2222;
    if (stall) nstall++;
    chk("dl_stall_cnt", nstall, 5);
    chk("dl_data", rdata, 32'hA5A5_5A5A);
    n_chk++;
    if ({cyc, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL dl_done: got %b expected 00", {cyc, err});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    ce = 1; we = 0; addr = 32'h0000_4000;
    dati = 32'h9999_9999;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({cyc, stall, err} !== 3'b110) begin
        n_fail++;
        $display("FAIL to_bus%0d: got %b expected 110",
                 i, {cyc, stall, err});
      end
    end
    tick();
    n_chk++;
    if ({cyc, stall, err} !== 3'b001) begin
      n_fail++;
      $display("FAIL to_done: got %b expected 001",
               {cyc, stall, err});
    end
    chk("to_rdata", rdata, 32'hA5A5_5A5A);
    idle_inputs();
    tick();
    chk("to_err_clear", {31'b0, err}, 32'h0);
  endtask

  task automatic test_flush();
    ce = 1; flush = 1;
    addr = 32'h0000_6000;
    #1;
    chk("fl_idle_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("fl_idle_nocyc", {31'b0, cyc}, 32'h0);
    flush = 0;
    tick();
    chk("fl_bus1", {31'b0, cyc}, 32'h1);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_bus3", {31'b0, cyc}, 32'h1);
    err_force = 1;
    tick();
    err_force = 0;
    n_chk++;
    if ({cyc, stall, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL fl_done: got %b expected 000",
               {cyc, stall, err});
    end
    idle_inputs();
    tick();
    n_chk++;
    if ({cyc, stall, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL fl_idle: got %b expected 000",
               {cyc, stall, err});
    end
  endtask

  task automatic test_ignore_idle();
    ack_force = 1; err_force = 1;
    tick();
    tick();
    idle_inputs();
    n_chk++;
    if ({cyc, err, stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL ign_idle: got %b expected 000",
               {cyc, err, stall});
    end
    chk("ign_rdata", rdata, 32'hA5A5_5A5A);
  endtask

  task automatic test_ack_err();
    ce = 1; we = 0; addr = 32'h0000_5000;
    dati = 32'h0BAD_F00D;
    tick();
    ack_force = 1; err_force = 1;
    tick();
    idle_inputs();
    chk("ae_data", rdata, 32'h0BAD_F00D);
    chk("ae_err", {31'b0, err}, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    ce = 1; we = 0; addr = 32'h0000_7000;
    dati = 32'h7777_7777;
    tick();
    chk("rm_bus", {31'b0, cyc}, 32'h1);
    #2;
    rst_n = 0;
    #1;
    n_chk++;
    if ({cyc, stb, stall, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL rm_drop: got %b expected 0000",
               {cyc, stb, stall, err});
    end
    chk("rm_rdata", rdata, 32'h0);
    #3;
    rst_n = 1;
    ce = 0;
    tick();
    ce = 1; addr = 32'h0000_7004;
    dati = 32'h600D_CAFE; ack_comb = 1;
    #1;
    chk("rm_req", {31'b0, stall}, 32'h1);
    tick();
    chk("rm_bus2", {31'b0, cyc}, 32'h1);
    tick();
    chk("rm_data", rdata, 32'h600D_CAFE);
    chk("rm_stall", {31'b0, stall}, 32'h0);
    idle_inputs();
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_load_comb();
    test_store();
    test_load_delayed();
    test_timeout();
    test_flush();
    test_ignore_idle();
    test_ack_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
